// File: rtl/addsub_stim_checker_if.sv
// Operand/result bus between the stimulus checker and the adder/subtractor under test.
// The checker is the master (drives operands); the unit under test is the slave.
interface addsub_stim_checker_if;
  logic [2:0] a;
  logic [2:0] b;
  logic       c_in;
  logic       add;
  logic [2:0] s;
  logic       c_out;

  modport master (output a, output b, output c_in, output add, input s, input c_out);
  modport slave  (input a, input b, input c_in, input add, output s, output c_out);
endinterface

// File: rtl/addsub_stim_checker.sv
// LFSR-driven stimulus generator and result checker for a 3-bit adder/subtractor.
// Optional macro ADDSUB_CHK_FIRSTERR_EN adds first_err/first_err_vld capture of the first failing vector.
module addsub_stim_checker #(
  parameter int         NUM_VEC = 50,
  parameter int         LAT     = 1,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  addsub_stim_checker_if.master        dut_if,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [7:0]                   err_cnt
`ifdef ADDSUB_CHK_FIRSTERR_EN
  ,
  output logic [7:0]                   first_err,
  output logic                         first_err_vld
`endif
);

  localparam int DATA_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  lfsr;
  logic [7:0]  vec_cnt;
  logic [1:0]  drain_cnt;
  logic        start_ok;
  logic        issue;
  logic        mismatch;
  logic [7:0]  vec_p0;
  logic        vld_p [LAT];
  logic [3:0]  exp_p [LAT];
`ifdef ADDSUB_CHK_FIRSTERR_EN
  logic [7:0]  vec_p [LAT];
`endif

  // Vector layout is {add, c_in, b, a}; result is {c_out, s}, taken mod 16.
  function automatic logic [3:0] calc_expected(input logic [7:0] v);
    logic signed [DATA_W+1:0] a_s;
    logic signed [DATA_W+1:0] b_s;
    logic signed [DATA_W+1:0] ci_s;
    logic signed [DATA_W+1:0] res_s;
    a_s  = signed'({2'b00, v[DATA_W-1:0]});
    b_s  = signed'({2'b00, v[2*DATA_W-1:DATA_W]});
    ci_s = signed'({4'b0000, v[6]});
    if (v[7]) res_s = a_s + b_s + ci_s;
    else      res_s = a_s - b_s - ci_s;
    return res_s[3:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (vec_cnt == 8'(NUM_VEC - 1)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'(LAT - 1)) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign issue    = (state == RUN);
  assign vec_p0   = issue ? lfsr : 8'h00;
  assign mismatch = vld_p[LAT-1] && ({dut_if.c_out, dut_if.s} != exp_p[LAT-1]);

  assign {dut_if.add, dut_if.c_in, dut_if.b, dut_if.a} = vec_p0;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_cnt == 8'd0);

  // Control state: FSM, LFSR, counters, valid pipeline, error accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED;
      vec_cnt   <= 8'd0;
      drain_cnt <= 2'd0;
      err_cnt   <= 8'd0;
      for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        lfsr      <= SEED;
        vec_cnt   <= 8'd0;
        drain_cnt <= 2'd0;
        err_cnt   <= 8'd0;
        for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
      end else begin
        if (issue) begin
          lfsr    <= lfsr_step(lfsr);
          vec_cnt <= vec_cnt + 8'd1;
        end
        drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        if (mismatch) err_cnt <= sat_inc(err_cnt);
        vld_p[0] <= issue;
        for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
      end
    end
  end

`ifdef ADDSUB_CHK_FIRSTERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err     <= 8'h00;
      first_err_vld <= 1'b0;
    end else if (start_ok) begin
      first_err     <= 8'h00;
      first_err_vld <= 1'b0;
    end else if (mismatch && !first_err_vld) begin
      first_err     <= vec_p[LAT-1];
      first_err_vld <= 1'b1;
    end
  end
`endif

  // Expected-result pipeline p0..p(LAT-1); data only, qualified by vld_p.
  always_ff @(posedge clk) begin
    exp_p[0] <= calc_expected(vec_p0);
    for (int i = 1; i < LAT; i++) exp_p[i] <= exp_p[i-1];
`ifdef ADDSUB_CHK_FIRSTERR_EN
    vec_p[0] <= vec_p0;
    for (int i = 1; i < LAT; i++) vec_p[i] <= vec_p[i-1];
`endif
  end

endmodule

// File: doc/addsub_stim_checker.md
ADDSUB_STIM_CHECKER -- requirements
Module: addsub_stim_checker

Interface
REQ-001 Parameter NUM_VEC, default 50, number of operand vectors issued per run (1..255).
REQ-002 Parameter LAT, default 1, clock cycles from operand drive to DUT result sampling (1..4).
REQ-003 Parameter SEED, default 8'hA5, non-zero 8-bit LFSR seed loaded at reset and at each start.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse to begin a run; ignored unless state is IDLE or DONE.
REQ-007 a, b  output  3 each  operands to the adder/subtractor under test.
REQ-008 c_in  output  1  carry/borrow-in to the unit under test.
REQ-009 add  output  1  operation select to the unit under test: 1 = add, 0 = subtract.
REQ-010 s  input  3  result from the unit under test.
REQ-011 c_out  input  1  carry/borrow-out from the unit under test.
REQ-012 busy  output  1  high while state is RUN or DRAIN.
REQ-013 done  output  1  high in DONE state.
REQ-014 pass  output  1  high in DONE when err_cnt == 0.
REQ-015 err_cnt  output  8  count of mismatching results, saturating at 255.

Function
REQ-016 States: IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after NUM_VEC vectors issued; DRAIN->DONE after LAT further cycles; DONE->RUN on start.
REQ-017 In RUN, one vector per cycle: {add, c_in, b, a} = 8 LSBs of an 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4), stepped every RUN cycle.
REQ-018 Outside RUN, a, b, c_in, add are driven 0.
REQ-019 Expected result per vector: add=1 -> {c_out,s} = a + b + c_in; add=0 -> {c_out,s} = ({0,a} - {0,b} - c_in) mod 16, c_out = borrow bit 3.
REQ-020 Expected values are held in a LAT-deep shift pipeline with a valid bit per stage; only stages with valid=1 are compared.
REQ-021 Compare the stage issued LAT cycles earlier against s and c_out on the same edge; any bit mismatch increments err_cnt by 1.
REQ-022 err_cnt saturates at 255; no wrap.
REQ-023 Vector counter is 8 bits, counts issued vectors, cleared on entry to RUN.
REQ-024 start while in DONE clears err_cnt, pipeline valids and vector counter, reloads SEED, then enters RUN the next cycle.
REQ-025 start while RUN or DRAIN has no effect.
REQ-026 Last compare of a run occurs in the final DRAIN cycle; done asserts on the following cycle.

Reset
REQ-027 rst asserted: state=IDLE, LFSR=SEED, err_cnt=0, vector counter=0, all pipeline valids=0, all outputs 0.
REQ-028 rst mid-run aborts immediately; no pending compare updates err_cnt after rst deasserts.

Configuration
REQ-029 Macro ADDSUB_CHK_FIRSTERR_EN defined: extra output first_err (8 bits, {add,c_in,b,a} of the first mismatching vector) and first_err_vld (1 bit), both cleared at reset and at start; without the macro neither port exists and behaviour is otherwise identical.

Verification
REQ-030 Ideal registered adder/subtractor model, LAT=1, NUM_VEC=50, start pulse -> 50 vectors issued, done after 51 cycles from first vector, pass=1, err_cnt=0.
REQ-031 Model with s[0] stuck at 0 -> err_cnt equals count of expected results with s[0]=1; pass=0.
REQ-032 Directed check a=7,b=1,c_in=1,add=1 expects s=1,c_out=1; a=0,b=1,c_in=0,add=0 expects s=7,c_out=1.
REQ-033 Model always inverting c_out, NUM_VEC=255 then second run NUM_VEC=255 without reset -> err_cnt=255 each run (cleared by start), no wrap.
REQ-034 rst pulse at vector 20 of 50 -> IDLE, all outputs 0, err_cnt=0; subsequent start produces same vector sequence as first run.
REQ-035 start pulses during RUN and DRAIN -> ignored; LAT=4 run completes with exactly NUM_VEC compares.
